// File: rtl/apogee_ce_gen.sv
// Apogee clock-enable generator: CPU f1/f2, pixel, I/O and PIT strobes.
// Optional turbo divisor is enabled by defining APOGEE_CE_TURBO_EN.
module apogee_ce_gen #(
  parameter int CPU_DIV       = 28,
  parameter int CPU_DIV_TURBO = 14,
  parameter int F2_PHASE      = 2,
  parameter int PIX_DIV       = 6,
  parameter int PIT_DIV       = 28
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic turbo,
  input  logic pause,
  output logic f1,
  output logic f2,
  output logic clk_pix,
  output logic clk_pix2x,
  output logic clk_io,
  output logic ce_pit,
  output logic cpu_active,
  output logic turbo_active
);

`ifdef APOGEE_CE_TURBO_EN
  localparam int CMAX = (CPU_DIV > CPU_DIV_TURBO)
                      ? CPU_DIV : CPU_DIV_TURBO;
`else
  localparam int CMAX = CPU_DIV;
  localparam int turbo_div_unused = CPU_DIV_TURBO;
`endif
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int PW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int TW = (PIT_DIV > 1) ? $clog2(PIT_DIV) : 1;

  localparam logic [CW-1:0] F2_AT  = CW'(F2_PHASE - 1);
  localparam logic [CW-1:0] N_LAST = CW'(CPU_DIV - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PIX_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(PIX_DIV / 2 - 1);
  localparam logic [TW-1:0] T_LAST = TW'(PIT_DIV - 1);

  logic          started;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic [CW-1:0] nlast;
  logic          nturbo;
  logic          period_start;
  logic [PW-1:0] pcnt;
  logic [TW-1:0] tcnt;

  assign period_start = !started || (cnt == last);

`ifdef APOGEE_CE_TURBO_EN
  localparam logic [CW-1:0] T_LAST_CPU = CW'(CPU_DIV_TURBO - 1);
  always_comb begin
    nlast  = turbo ? T_LAST_CPU : N_LAST;
    nturbo = turbo;
  end
`else
  logic turbo_unused;
  assign turbo_unused = turbo;
  always_comb begin
    nlast  = N_LAST;
    nturbo = 1'b0;
  end
`endif

  // Divisor and pause are only taken at a period boundary
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      started      <= 1'b0;
      cnt          <= '0;
      last         <= N_LAST;
      turbo_active <= 1'b0;
      cpu_active   <= 1'b1;
      f1           <= 1'b0;
      f2           <= 1'b0;
    end else begin
      started <= 1'b1;
      if (period_start) begin
        cnt          <= '0;
        last         <= nlast;
        turbo_active <= nturbo;
        cpu_active   <= ~pause;
        f1           <= ~pause;
        f2           <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
        f1  <= 1'b0;
        f2  <= cpu_active && (cnt == F2_AT);
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      pcnt      <= '0;
      clk_pix   <= 1'b0;
      clk_pix2x <= 1'b0;
    end else begin
      pcnt      <= (pcnt == P_LAST) ? '0 : pcnt + 1'b1;
      clk_pix   <= (pcnt == P_LAST);
      clk_pix2x <= (pcnt == P_LAST) || (pcnt == P_HALF);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      tcnt   <= '0;
      ce_pit <= 1'b0;
      clk_io <= 1'b0;
    end else begin
      tcnt   <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
      ce_pit <= (tcnt == T_LAST);
      clk_io <= ~clk_io;
    end
  end

endmodule

// File: tb/tb_apogee_ce_gen.sv
// Directed bench for apogee_ce_gen: logs outputs per edge after reset
// release and checks them against hand-computed edge numbers.
module tb_apogee_ce_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic turbo = 1'b0;
  logic pause = 1'b0;
  logic f1, f2, clk_pix, clk_pix2x, clk_io, ce_pit;
  logic cpu_active, turbo_active;

  int n_run = 0;
  int n_fail = 0;
  int e = 0;

  bit f1_l [0:199];
  bit f2_l [0:199];
  bit px_l [0:199];
  bit p2_l [0:199];
  bit io_l [0:199];
  bit pt_l [0:199];
  bit ca_l [0:199];
  bit ta_l [0:199];

  apogee_ce_gen dut (
    .clk_sys(clk),
    .reset_n(reset_n),
    .turbo(turbo),
    .pause(pause),
    .f1(f1),
    .f2(f2),
    .clk_pix(clk_pix),
    .clk_pix2x(clk_pix2x),
    .clk_io(clk_io),
    .ce_pit(ce_pit),
    .cpu_active(cpu_active),
    .turbo_active(turbo_active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (reset_n) begin
      e = e + 1;
      if (e < 200) begin
        f1_l[e] = f1;
        f2_l[e] = f2;
        px_l[e] = clk_pix;
        p2_l[e] = clk_pix2x;
        io_l[e] = clk_io;
        pt_l[e] = ce_pit;
        ca_l[e] = cpu_active;
        ta_l[e] = turbo_active;
      end
    end else begin
      e = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_edge(input int n);
    int guard = 0;
    while (e < n && guard < 1000) begin
      @(posedge clk);
      #2;
      guard++;
    end
    chk("edge_timeout", (e >= n), 1);
  endtask

  task automatic start(input logic t, input logic p);
    @(negedge clk);
    reset_n = 1'b0;
    turbo = t;
    pause = p;
    for (int i = 0; i < 200; i++) begin
      f1_l[i] = 0; f2_l[i] = 0; px_l[i] = 0; p2_l[i] = 0;
      io_l[i] = 0; pt_l[i] = 0; ca_l[i] = 0; ta_l[i] = 0;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic base_checks(input string s);
    int cnt = 0;
    wait_edge(60);
    chk({s, "f1@1"}, f1_l[1], 1);
    chk({s, "f1@2"}, f1_l[2], 0);
    chk({s, "f1@28"}, f1_l[28], 0);
    chk({s, "f1@29"}, f1_l[29], 1);
    chk({s, "f1@57"}, f1_l[57], 1);
    chk({s, "f2@3"}, f2_l[3], 1);
    chk({s, "f2@2"}, f2_l[2], 0);
    chk({s, "f2@31"}, f2_l[31], 1);
    chk({s, "pix@5"}, px_l[5], 0);
    chk({s, "pix@6"}, px_l[6], 1);
    chk({s, "pix@12"}, px_l[12], 1);
    chk({s, "p2x@3"}, p2_l[3], 1);
    chk({s, "p2x@4"}, p2_l[4], 0);
    chk({s, "p2x@6"}, p2_l[6], 1);
    chk({s, "p2x@9"}, p2_l[9], 1);
    chk({s, "p2x@12"}, p2_l[12], 1);
    chk({s, "io@1"}, io_l[1], 1);
    chk({s, "io@2"}, io_l[2], 0);
    chk({s, "io@3"}, io_l[3], 1);
    chk({s, "pit@27"}, pt_l[27], 0);
    chk({s, "pit@28"}, pt_l[28], 1);
    chk({s, "pit@56"}, pt_l[56], 1);
    for (int i = 1; i <= 60; i++) cnt += f1_l[i];
    chk({s, "f1_count"}, cnt, 3);
    cnt = 0;
    for (int i = 1; i <= 60; i++) cnt += f2_l[i];
    chk({s, "f2_count"}, cnt, 3);
    chk({s, "tact@30"}, ta_l[30], 0);
  endtask

  initial begin
    #12;
    chk("rst_f1", f1, 0);
    chk("rst_f2", f2, 0);
    chk("rst_io", clk_io, 0);
    chk("rst_pix", clk_pix, 0);
    chk("rst_cact", cpu_active, 1);
    chk("rst_tact", turbo_active, 0);

    start(1'b0, 1'b0);
    base_checks("s1_");

`ifdef APOGEE_CE_TURBO_EN
    start(1'b0, 1'b0);
    wait_edge(30);
    turbo = 1'b1;
    wait_edge(100);
    chk("tu_f1@57", f1_l[57], 1);
    chk("tu_f1@71", f1_l[71], 1);
    chk("tu_f1@85", f1_l[85], 1);
    chk("tu_f1@99", f1_l[99], 1);
    chk("tu_f2@73", f2_l[73], 1);
    chk("tu_tact@56", ta_l[56], 0);
    chk("tu_tact@57", ta_l[57], 1);
    turbo = 1'b0;
    wait_edge(145);
    chk("tu_f1@113", f1_l[113], 1);
    chk("tu_f1@127", f1_l[127], 0);
    chk("tu_f1@141", f1_l[141], 1);
    chk("tu_tact@113", ta_l[113], 0);
`else
    start(1'b1, 1'b0);
    wait_edge(60);
    chk("off_f1@15", f1_l[15], 0);
    chk("off_f1@29", f1_l[29], 1);
    chk("off_f1@57", f1_l[57], 1);
    chk("off_tact@30", ta_l[30], 0);
    turbo = 1'b0;
`endif

    start(1'b0, 1'b0);
    wait_edge(30);
    pause = 1'b1;
    wait_edge(90);
    pause = 1'b0;
    wait_edge(120);
    chk("pa_f2@31", f2_l[31], 1);
    chk("pa_f1@57", f1_l[57], 0);
    chk("pa_f2@59", f2_l[59], 0);
    chk("pa_f1@85", f1_l[85], 0);
    chk("pa_f2@87", f2_l[87], 0);
    chk("pa_cact@57", ca_l[57], 0);
    chk("pa_f1@113", f1_l[113], 1);
    chk("pa_f2@115", f2_l[115], 1);
    chk("pa_cact@113", ca_l[113], 1);

    start(1'b0, 1'b0);
    wait_edge(28);
    pause = 1'b1;
    turbo = 1'b1;
    wait_edge(30);
    pause = 1'b0;
    turbo = 1'b0;
    wait_edge(80);
    chk("bd_f1@29", f1_l[29], 0);
    chk("bd_f2@31", f2_l[31], 0);
    chk("bd_cact@29", ca_l[29], 0);
`ifdef APOGEE_CE_TURBO_EN
    chk("bd_tact@29", ta_l[29], 1);
    chk("bd_f1@43", f1_l[43], 1);
    chk("bd_f1@71", f1_l[71], 1);
    chk("bd_f1@57", f1_l[57], 0);
`else
    chk("bd_tact@29", ta_l[29], 0);
    chk("bd_f1@43", f1_l[43], 0);
    chk("bd_f1@57", f1_l[57], 1);
`endif

    start(1'b0, 1'b0);
    wait_edge(40);
    reset_n = 1'b0;
    #1;
    chk("ar_f1", f1, 0);
    chk("ar_f2", f2, 0);
    chk("ar_pix", clk_pix, 0);
    chk("ar_p2x", clk_pix2x, 0);
    chk("ar_io", clk_io, 0);
    chk("ar_pit", ce_pit, 0);
    chk("ar_cact", cpu_active, 1);
    repeat (3) @(posedge clk);
    start(1'b0, 1'b0);
    base_checks("ar_");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
